// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are held for MULT settling, then the result is returned over a valid/ready channel.

module alu_arbiter_port (
    input  logic valid,
    input  logic gnt,
    input  logic idle,
    output logic ready,
    output logic take
);
    assign ready = idle & gnt;
    assign take  = valid & ready;
endmodule

module alu_arbiter #(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [3:0]  MULT_OP     = 4'b0101,
    parameter int          MULT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [3:0]            req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [3:0]            req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  req1_ready,
    output logic [3:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    input  logic                  rsp_ready
);
    localparam int NREQ = 2;
    localparam int CW   = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    typedef struct packed {
        logic [3:0]            op;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } alu_req_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last_grant;
    alu_req_t [NREQ-1:0]   req;
    alu_req_t              sel_req;
    logic [NREQ-1:0]       req_valid, req_ready, gnt, take;
    logic                  idle, accept, capture;

    assign req[0]    = '{op: req0_op, a: req0_a, b: req0_b};
    assign req[1]    = '{op: req1_op, a: req1_a, b: req1_b};
    assign req_valid = {req1_valid, req0_valid};
    assign idle      = (state_q == IDLE);

    // On a tie the requester that did not win last time gets the ALU.
    always_comb begin
        gnt = '0;
        case (req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_port
        alu_arbiter_port u_port (
            .valid (req_valid[i]),
            .gnt   (gnt[i]),
            .idle  (idle),
            .ready (req_ready[i]),
            .take  (take[i])
        );
    end

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign accept     = |take;
    assign sel_req    = take[1] ? req[1] : req[0];
    assign rsp_valid  = (state_q == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    cnt_d   = '0;
                end
            end
            EXEC: begin
                // MULT keeps operands on the ALU until the product has settled.
                if (alu_op == MULT_OP && cnt_q < CW'(MULT_CYCLES - 1)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                alu_op     <= sel_req.op;
                alu_a      <= sel_req.a;
                alu_b      <= sel_req.b;
                rsp_id     <= take[1];
                last_grant <= take[1];
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU stand-in (ADD/SUB/MULT, others yield 0).

module tb_alu_arbiter;
    localparam int         DW      = 32;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MULT = 4'b0101;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]    req0_op, req1_op, alu_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
    logic          alu_zero, rsp_valid, rsp_id, rsp_zero, rsp_ready;

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter #(.DATA_WIDTH(DW), .MULT_OP(OP_MULT), .MULT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_MULT: alu_result = alu_a * alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int id, input logic v, input logic [3:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rsp_ready = 1'b1;
        drive(0, 1'b0, 4'd0, '0, '0);
        drive(1, 1'b0, 4'd0, '0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Issue one op from an idle arbiter with rsp_ready high; checks latency and response.
    task automatic run_op(input string tag, input int id, input logic [3:0] op,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input int lat,
                          input logic [DW-1:0] res, input logic z);
        int cyc;
        @(negedge clk);
        drive(id, 1'b1, op, a, b);
        #1;
        check({tag, "_rdy"},   64'(id == 0 ? req0_ready : req1_ready), 64'(1));
        check({tag, "_nrdy"},  64'(id == 0 ? req1_ready : req0_ready), 64'(0));
        @(negedge clk);
        drive(id, 1'b0, 4'd0, '0, '0);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            check({tag, "_hold_a"}, 64'(alu_a), 64'(a));
            check({tag, "_hold_b"}, 64'(alu_b), 64'(b));
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"},  64'(cyc), 64'(lat));
        check({tag, "_id"},   64'(rsp_id), 64'(id));
        check({tag, "_res"},  64'(rsp_result), 64'(res));
        check({tag, "_zero"}, 64'(rsp_zero), 64'(z));
        @(negedge clk);
        check({tag, "_drop"}, 64'(rsp_valid), 64'(0));
    endtask

    int gnt_seen[4];
    int gc;
    int cyc;

    initial begin
        do_reset();
        reset = 1'b0;
        #1;
        check("rst_valid", 64'(rsp_valid), 64'(0));
        check("rst_alu_a", 64'(alu_a), 64'(0));
        check("rst_res",   64'(rsp_result), 64'(0));
        reset = 1'b1;

        run_op("add",   0, OP_ADD,  32'd5, 32'd7, 1, 32'd12, 1'b0);
        run_op("sub",   1, OP_SUB,  32'd9, 32'd9, 1, 32'd0, 1'b1);
        run_op("subw",  0, OP_SUB,  32'd0, 32'd1, 1, 32'hFFFF_FFFF, 1'b0);
        run_op("addw",  1, OP_ADD,  32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b1);
        run_op("undef", 0, 4'b1111, 32'd3, 32'd4, 1, 32'd0, 1'b1);
        run_op("mul",   1, OP_MULT, 32'd3, 32'd5, 2, 32'd15, 1'b0);
        run_op("mulhi", 0, OP_MULT, 32'h0001_0000, 32'h0001_0000, 2, 32'd0, 1'b1);

        // Both requesters valid from reset: grants must alternate starting with 0.
        do_reset();
        drive(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        drive(1, 1'b1, OP_SUB, 32'd10, 32'd3);
        gc = 0;
        for (int c = 0; c < 60 && gc < 4; c++) begin
            #1;
            check("rdy_excl", 64'(req0_ready & req1_ready), 64'(0));
            if (req0_ready | req1_ready) begin
                gnt_seen[gc] = req1_ready ? 1 : 0;
                gc++;
            end
            if (rsp_valid) check("rr_res", 64'(rsp_result), rsp_id ? 64'(7) : 64'(3));
            @(negedge clk);
        end
        check("rr_count", 64'(gc), 64'(4));
        for (int i = 0; i < 4; i++) check($sformatf("rr_gnt%0d", i), 64'(gnt_seen[i]), 64'(i % 2));
        drive(0, 1'b0, 4'd0, '0, '0);
        drive(1, 1'b0, 4'd0, '0, '0);
        repeat (4) @(negedge clk);
        check("rr_idle", 64'(rsp_valid), 64'(0));

        // Response back-pressure: fields stay put and nothing new is accepted.
        rsp_ready = 1'b0;
        drive(1, 1'b1, OP_ADD, 32'd2, 32'd3);
        @(negedge clk);
        drive(1, 1'b0, 4'd0, '0, '0);
        @(negedge clk);
        drive(0, 1'b1, OP_ADD, 32'd1, 32'd1);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid", 64'(rsp_valid), 64'(1));
            check("bp_res",   64'(rsp_result), 64'(5));
            check("bp_id",    64'(rsp_id), 64'(1));
            check("bp_rdy0",  64'(req0_ready), 64'(0));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_rdy0_resp", 64'(req0_ready), 64'(0));
        @(negedge clk);
        #1;
        check("bp_rel_valid", 64'(rsp_valid), 64'(0));
        check("bp_rel_rdy0",  64'(req0_ready), 64'(1));
        @(negedge clk);
        drive(0, 1'b0, 4'd0, '0, '0);
        @(negedge clk);
        check("bp_next_valid", 64'(rsp_valid), 64'(1));
        check("bp_next_res",   64'(rsp_result), 64'(2));
        check("bp_next_id",    64'(rsp_id), 64'(0));
        @(negedge clk);

        // Reset in the middle of a MULT, then a tie must go to requester 0.
        drive(1, 1'b1, OP_MULT, 32'h0001_0000, 32'd3);
        @(negedge clk);
        drive(1, 1'b0, 4'd0, '0, '0);
        check("mr_exec_op", 64'(alu_op), 64'(OP_MULT));
        drive(0, 1'b1, OP_ADD, 32'd6, 32'd6);
        drive(1, 1'b1, OP_ADD, 32'd1, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mr_op",    64'(alu_op), 64'(0));
        check("mr_a",     64'(alu_a), 64'(0));
        check("mr_b",     64'(alu_b), 64'(0));
        check("mr_valid", 64'(rsp_valid), 64'(0));
        check("mr_id",    64'(rsp_id), 64'(0));
        check("mr_res",   64'(rsp_result), 64'(0));
        check("mr_zero",  64'(rsp_zero), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mr_tie_rdy0", 64'(req0_ready), 64'(1));
        check("mr_tie_rdy1", 64'(req1_ready), 64'(0));
        @(negedge clk);
        drive(0, 1'b0, 4'd0, '0, '0);
        drive(1, 1'b0, 4'd0, '0, '0);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("mr_lat", 64'(cyc), 64'(1));
        check("mr_rid", 64'(rsp_id), 64'(0));
        check("mr_rres", 64'(rsp_result), 64'(12));
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
